// File: rtl/pux_arb.sv
// pux_arb: two-client opcode arbiter in front of a single pux_si processing unit.
//
// Purpose:
//   Accepts opcodes from two AXI-stream requesters. The PU is granted
//   round-robin, and the grant is held until the PU returns its status beat.
//   That status is then routed back to the client that owns the transaction.
//   A watchdog synthesises an all-ones status if the PU never answers, so a
//   client is never left hung.
//
// Ports:
//   axis_clk, axis_rstn             clock, asynchronous active-low reset
//   s0_opcode_*, s1_opcode_*        client opcode streams (data/valid/ready)
//   m_opcode_*                      opcode stream to the PU
//   m_status_*                      status stream from the PU
//   s0_status_*, s1_status_*        status streams back to the clients
//   grant_id                        owner of the current or last transaction
//   busy                            high whenever the FSM is not idle
//   timeout_err                     one-cycle pulse when the watchdog fires
module pux_arb #(
  parameter int OPCW  = 8,
  parameter int DATAW = 16,
  parameter int TMO   = 1023,
  parameter int TMOW  = 10
) (
  input  logic             axis_clk,
  input  logic             axis_rstn,
  input  logic [OPCW-1:0]  s0_opcode_data,
  input  logic             s0_opcode_valid,
  output logic             s0_opcode_ready,
  input  logic [OPCW-1:0]  s1_opcode_data,
  input  logic             s1_opcode_valid,
  output logic             s1_opcode_ready,
  output logic [OPCW-1:0]  m_opcode_data,
  output logic             m_opcode_valid,
  input  logic             m_opcode_ready,
  input  logic [DATAW-1:0] m_status_data,
  input  logic             m_status_valid,
  output logic             m_status_ready,
  output logic [DATAW-1:0] s0_status_data,
  output logic             s0_status_valid,
  input  logic             s0_status_ready,
  output logic [DATAW-1:0] s1_status_data,
  output logic             s1_status_valid,
  input  logic             s1_status_ready,
  output logic             grant_id,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value on the last WAIT cycle before the watchdog fires.
  localparam logic [TMOW-1:0] WDOG_LAST = TMOW'((TMO == 0) ? 0 : (TMO - 1));

  state_t            state_reg, state_next;
  logic [OPCW-1:0]   opcode_reg, opcode_next;
  logic [DATAW-1:0]  status_reg, status_next;
  logic              grant_reg, grant_next;
  logic              last_grant_reg, last_grant_next;
  logic              tmo_reg, tmo_next;
  logic [TMOW-1:0]   wdog_reg, wdog_next;

  logic              any_valid;
  logic              sel_id;
  logic              take;
  logic              owner_ready;
  logic [1:0]        cl_status_valid;
  logic [DATAW-1:0]  cl_status_data [2];

  // Selection is purely combinational. When both clients request, the one
  // that did not win last time is chosen. Ready is gated by reset so that
  // every output is low while the block is held in reset.
  always_comb begin
    any_valid = s0_opcode_valid | s1_opcode_valid;
    sel_id    = (s0_opcode_valid && s1_opcode_valid) ? ~last_grant_reg : s1_opcode_valid;
    take      = (state_reg == IDLE) && any_valid && axis_rstn;
  end

  assign s0_opcode_ready = take & ~sel_id;
  assign s1_opcode_ready = take &  sel_id;

  assign owner_ready = grant_reg ? s1_status_ready : s0_status_ready;

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state_reg      <= IDLE;
      opcode_reg     <= '0;
      status_reg     <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      tmo_reg        <= 1'b0;
      wdog_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      opcode_reg     <= opcode_next;
      status_reg     <= status_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      tmo_reg        <= tmo_next;
      wdog_reg       <= wdog_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    opcode_next     = opcode_reg;
    status_next     = status_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    tmo_next        = 1'b0;
    wdog_next       = wdog_reg;

    case (state_reg)
      IDLE: begin
        if (take) begin
          opcode_next     = sel_id ? s1_opcode_data : s0_opcode_data;
          grant_next      = sel_id;
          last_grant_next = sel_id;
          state_next      = ISSUE;
        end
      end

      ISSUE: begin
        if (m_opcode_ready) begin
          wdog_next  = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        // A real status arriving on the expiry cycle takes priority over
        // the synthesised error.
        if (m_status_valid) begin
          status_next = m_status_data;
          state_next  = RESP;
        end else if (TMO != 0) begin
          if (wdog_reg == WDOG_LAST) begin
            status_next = '1;
            tmo_next    = 1'b1;
            state_next  = RESP;
          end else begin
            wdog_next = wdog_reg + TMOW'(1);
          end
        end
      end

      RESP: begin
        if (owner_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Status routing: only the owning client sees valid and data; the other
  // client's data is forced to zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    assign cl_status_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    assign cl_status_data[gi]  = cl_status_valid[gi] ? status_reg : '0;
  end

  assign s0_status_valid = cl_status_valid[0];
  assign s0_status_data  = cl_status_data[0];
  assign s1_status_valid = cl_status_valid[1];
  assign s1_status_data  = cl_status_data[1];

  assign m_opcode_data  = opcode_reg;
  assign m_opcode_valid = (state_reg == ISSUE);
  assign m_status_ready = (state_reg == WAIT);
  assign grant_id       = grant_reg;
  assign busy           = (state_reg != IDLE);
  assign timeout_err    = tmo_reg;

endmodule
